// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue controller for the 32-bit ALU.
// Takes one instruction per in_valid/in_ready handshake and maps it to an ALU operation
// code and operands. Drives those operands from registers, captures the ALU result, and
// returns it on a second out_valid/out_ready handshake. Only one instruction is in flight.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [IMM_W-1:0] imm,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpNor  = 4'b0010;
  localparam logic [3:0] OpAdd  = 4'b0011;
  localparam logic [3:0] OpSub  = 4'b0100;
  localparam logic [3:0] OpNone = 4'b1111;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_illegal_q, out_illegal_d;

  logic [3:0]       dec_op;
  logic [WIDTH-1:0] dec_b;
  logic             dec_illegal;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;
  logic             accept;

  assign imm_sext = {{(WIDTH - IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext = {{(WIDTH - IMM_W){1'b0}}, imm};

  // Instruction decode: operation code and operand B source.
  always_comb begin
    dec_op      = OpNone;
    dec_b       = '0;
    dec_illegal = 1'b0;
    unique case (opcode)
      6'h00: begin
        dec_b = rt_data;
        unique case (funct)
          6'h20, 6'h21: dec_op = OpAdd;
          6'h22, 6'h23: dec_op = OpSub;
          6'h24:        dec_op = OpAnd;
          6'h25:        dec_op = OpOr;
          6'h27:        dec_op = OpNor;
          default:      dec_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin
        dec_op = OpAdd;
        dec_b  = imm_sext;
      end
      6'h0C: begin
        dec_op = OpAnd;
        dec_b  = imm_zext;
      end
      6'h0D: begin
        dec_op = OpOr;
        dec_b  = imm_zext;
      end
      6'h04, 6'h05: begin
        dec_op = OpSub;
        dec_b  = rt_data;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op = OpNone;
      dec_b  = '0;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  // Next-state and datapath register updates.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    illegal_d     = illegal_q;
    result_d      = result_q;
    zero_d        = zero_q;
    out_illegal_d = out_illegal_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d      = dec_op;
          a_d       = dec_illegal ? '0 : rs_data;
          b_d       = dec_b;
          illegal_d = dec_illegal;
          state_d   = StExec;
        end
      end
      StExec: begin
        // Illegal instructions report a fixed zero result regardless of the ALU.
        result_d      = illegal_q ? '0 : alu_result;
        zero_d        = illegal_q ? 1'b1 : alu_zero;
        out_illegal_d = illegal_q;
        state_d       = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= OpNone;
      a_q           <= '0;
      b_q           <= '0;
      illegal_q     <= 1'b0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      illegal_q     <= illegal_d;
      result_q      <= result_d;
      zero_q        <= zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign alu_operation = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign out_valid     = (state_q == StDone);
  assign out_result    = result_q;
  assign out_zero      = zero_q;
  assign out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU attached and a
// reference model that evaluates each instruction's meaning directly.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic [3:0]  alu_operation;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .IMM_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  // ALU model; an unused code yields a non-zero pattern so forcing on illegal is visible.
  always_comb begin
    case (alu_operation)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = ~(alu_a | alu_b);
      4'b0011: alu_result = alu_a + alu_b;
      4'b0100: alu_result = alu_a - alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  // Meaning of each instruction, evaluated straight from its mnemonic.
  function automatic exp_t ref_model(logic [5:0] opc, logic [5:0] fn, logic [31:0] rs,
                                     logic [31:0] rt, logic [15:0] im);
    exp_t e;
    logic [31:0] sx;
    logic [31:0] zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0, im};
    e.ill = 1'b0;
    e.a = rs;
    if (opc == 6'h00 && (fn == 6'h20 || fn == 6'h21)) begin e.op = 4'd3; e.b = rt; e.res = rs + rt; end
    else if (opc == 6'h00 && (fn == 6'h22 || fn == 6'h23)) begin e.op = 4'd4; e.b = rt; e.res = rs - rt; end
    else if (opc == 6'h00 && fn == 6'h24) begin e.op = 4'd0; e.b = rt; e.res = rs & rt; end
    else if (opc == 6'h00 && fn == 6'h25) begin e.op = 4'd1; e.b = rt; e.res = rs | rt; end
    else if (opc == 6'h00 && fn == 6'h27) begin e.op = 4'd2; e.b = rt; e.res = ~(rs | rt); end
    else if (opc == 6'h08 || opc == 6'h09 || opc == 6'h23 || opc == 6'h2B) begin
      e.op = 4'd3; e.b = sx; e.res = rs + sx;
    end
    else if (opc == 6'h0C) begin e.op = 4'd0; e.b = zx; e.res = rs & zx; end
    else if (opc == 6'h0D) begin e.op = 4'd1; e.b = zx; e.res = rs | zx; end
    else if (opc == 6'h04 || opc == 6'h05) begin e.op = 4'd4; e.b = rt; e.res = rs - rt; end
    else begin e.op = 4'hF; e.a = 32'h0; e.b = 32'h0; e.res = 32'h0; e.ill = 1'b1; end
    e.zero = e.ill ? 1'b1 : (e.res == 32'h0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive_fields(input logic [5:0] opc, input logic [5:0] fn,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [15:0] im);
    opcode = opc; funct = fn; rs_data = rs; rt_data = rt; imm = im;
  endtask

  // Full transaction; all driving and sampling happens on the falling edge.
  task automatic run_txn(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] im, input int hold);
    exp_t e;
    int   waited;
    e = ref_model(opc, fn, rs, rt, im);
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_idle", {31'h0, in_ready}, 32'h1);
    drive_fields(opc, fn, rs, rt, im);
    in_valid = 1'b1;
    @(negedge clk); // EXEC
    in_valid = 1'b0;
    check("alu_op", {28'h0, alu_operation}, {28'h0, e.op});
    check("alu_a", alu_a, e.a);
    check("alu_b", alu_b, e.b);
    check("in_ready_exec", {31'h0, in_ready}, 32'h0);
    check("out_valid_exec", {31'h0, out_valid}, 32'h0);
    @(negedge clk); // DONE
    check("out_valid_done", {31'h0, out_valid}, 32'h1);
    check("out_result", out_result, e.res);
    check("out_zero", {31'h0, out_zero}, {31'h0, e.zero});
    check("out_illegal", {31'h0, out_illegal}, {31'h0, e.ill});
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      drive_fields(6'h00, 6'h22, $urandom, $urandom, 16'(~im));
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid", {31'h0, out_valid}, 32'h1);
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
      check("hold_result", out_result, e.res);
      check("hold_zero", {31'h0, out_zero}, {31'h0, e.zero});
      check("hold_alu_op", {28'h0, alu_operation}, {28'h0, e.op});
    end
    out_ready = 1'b1;
    @(negedge clk); // IDLE
    out_ready = 1'b0;
    check("ret_valid", {31'h0, out_valid}, 32'h0);
    check("ret_in_ready", {31'h0, in_ready}, 32'h1);
    check("ret_alu_a_held", alu_a, e.a);
  endtask

  logic [5:0] legal_ops [9] = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h04, 6'h05};

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_fields(6'h0, 6'h0, 32'h0, 32'h0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_alu_op", {28'h0, alu_operation}, 32'hF);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_zero", {31'h0, out_zero}, 32'h0);
    check("rst_out_illegal", {31'h0, out_illegal}, 32'h0);

    run_txn(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 0);
    run_txn(6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0, 0);
    run_txn(6'h0C, 6'h00, 32'hF0F0_F0F0, 32'h0, 16'hFFFF, 0);
    run_txn(6'h08, 6'h00, 32'd1, 32'h0, 16'hFFFF, 1);
    run_txn(6'h00, 6'h2A, 32'h55, 32'h66, 16'h0, 0);
    run_txn(6'h00, 6'h27, 32'h0F0F_0000, 32'h0000_F0F0, 16'h0, 5);
    run_txn(6'h3F, 6'h20, 32'h1, 32'h2, 16'h3, 0);

    // Reset while in EXEC drops the transaction.
    @(negedge clk);
    drive_fields(6'h00, 6'h20, 32'd9, 32'd9, 16'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rexec_out_valid", {31'h0, out_valid}, 32'h0);
    check("rexec_in_ready", {31'h0, in_ready}, 32'h1);
    check("rexec_alu_op", {28'h0, alu_operation}, 32'hF);
    @(negedge clk);
    check("rexec_out_valid2", {31'h0, out_valid}, 32'h0);

    // Reset dominates a simultaneous handshake.
    drive_fields(6'h0D, 6'h00, 32'h1, 32'h0, 16'h00F0);
    in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    check("rhs_alu_op", {28'h0, alu_operation}, 32'hF);
    check("rhs_alu_a", alu_a, 32'h0);
    check("rhs_in_ready", {31'h0, in_ready}, 32'h1);

    for (int n = 0; n < 60; n++) begin
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] rs;
      logic [31:0] rt;
      opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
      fn  = 6'($urandom_range(32'h20, 32'h2A));
      rs  = $urandom;
      rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      run_txn(opc, fn, rs, rt, 16'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
